// File: rtl/mem_port_arbiter_if.sv
// Requester (CPU, video) and memory-port signals shared by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one block-RAM port between the CPU (C) and video line fetch (V); video bursts,
// CPU wait bounded. Define ARB_ROUND_ROBIN_EN for plain alternating arbitration instead.
module mem_port_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned MAX_WAIT  = 6
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef struct packed {
    logic valid;
    logic vid;
  } tag_t;

  logic          cpu_gnt_c;
  logic          vid_gnt_c;
  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;
  logic          cpu_rv_c;
  logic          vid_rv_c;
  tag_t          tag_q [READ_LAT];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_vid_q;

  // Conflicts go to whoever did not win last; lone requesters always win.
  always_comb begin
    vid_gnt_c = 1'b0;
    cpu_gnt_c = 1'b0;
    if (reset) begin
      vid_gnt_c = bus.vid_req & (~bus.cpu_req | ~last_vid_q);
      cpu_gnt_c = bus.cpu_req & ~vid_gnt_c;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      last_vid_q <= 1'b0;
    else if (vid_gnt_c | cpu_gnt_c)  last_vid_q <= vid_gnt_c;
  end
`else
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {ARB_IDLE, ARB_VID} state_t;

  state_t            state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [WAIT_W-1:0] wait_q;
  logic              cpu_forced_c;

  // Video wins unless the CPU has waited its limit or the burst is exhausted.
  always_comb begin
    cpu_forced_c = bus.cpu_req & (wait_q == WAIT_W'(MAX_WAIT));
    vid_gnt_c    = 1'b0;
    cpu_gnt_c    = 1'b0;
    if (reset) begin
      case (state_q)
        ARB_IDLE: vid_gnt_c = bus.vid_req & ~cpu_forced_c;
        ARB_VID:  vid_gnt_c = bus.vid_req & ~cpu_forced_c & (beat_q < BEAT_W'(BURST_LEN));
        default:  vid_gnt_c = 1'b0;
      endcase
      cpu_gnt_c = bus.cpu_req & ~vid_gnt_c;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      if (vid_gnt_c) begin
        state_q <= ARB_VID;
        beat_q  <= beat_q + BEAT_W'(1);
      end else begin
        state_q <= ARB_IDLE;
        beat_q  <= '0;
      end
      if (bus.cpu_req & ~cpu_gnt_c) begin
        if (wait_q != WAIT_W'(MAX_WAIT)) wait_q <= wait_q + WAIT_W'(1);
      end else begin
        wait_q <= '0;
      end
    end
  end
`endif

  // Memory port follows the granted requester in the grant cycle.
  always_comb begin
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    if (cpu_gnt_c) begin
      we_c    = bus.cpu_we;
      addr_c  = bus.cpu_addr;
      wdata_c = bus.cpu_wdata;
    end else if (vid_gnt_c) begin
      addr_c  = bus.vid_addr;
    end
  end

  // Owner tags ride alongside the memory read latency so returns land on the issuer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(READ_LAT); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_t'{valid: (cpu_gnt_c & ~bus.cpu_we) | vid_gnt_c, vid: vid_gnt_c};
      for (int i = 1; i < int'(READ_LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign cpu_rv_c = tag_q[READ_LAT-1].valid & ~tag_q[READ_LAT-1].vid;
  assign vid_rv_c = tag_q[READ_LAT-1].valid &  tag_q[READ_LAT-1].vid;

  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.vid_gnt    = vid_gnt_c;
  assign bus.mem_en     = cpu_gnt_c | vid_gnt_c;
  assign bus.mem_we     = we_c;
  assign bus.mem_addr   = addr_c;
  assign bus.mem_wdata  = wdata_c;
  assign bus.cpu_rvalid = cpu_rv_c;
  assign bus.vid_rvalid = vid_rv_c;
  assign bus.cpu_rdata  = cpu_rv_c ? bus.mem_rdata : '0;
  assign bus.vid_rdata  = vid_rv_c ? bus.mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single block-RAM port between two requesters: the CPU load/store/fetch path (port C) and the video line-fetch reader (port V).
- Sits between the CPU control FSM/datapath, the VGA fetch unit, and memory port A.
- Pipelines accesses at up to one per cycle and returns read data tagged to the issuing requester.
- Video has burst priority; a starvation counter bounds CPU wait.

Parameters:
- AW, 16, address width
- DW, 16, data width
- READ_LAT, 1, memory read latency in cycles (1..4)
- BURST_LEN, 8, maximum consecutive video grants per burst
- MAX_WAIT, 6, CPU wait cycles before forced CPU grant (1..15)

Ports:
- clock, in, 1, system clock
- reset, in, 1, asynchronous active-low reset
- cpu_req, in, 1, CPU access request; held until cpu_gnt
- cpu_we, in, 1, 1 = store, 0 = load/fetch
- cpu_addr, in, AW, CPU address
- cpu_wdata, in, DW, CPU store data
- cpu_gnt, out, 1, issue cycle for the CPU access
- cpu_rvalid, out, 1, CPU read data valid (1 cycle)
- cpu_rdata, out, DW, CPU read data
- vid_req, in, 1, video read request; held until vid_gnt
- vid_addr, in, AW, video address
- vid_gnt, out, 1, issue cycle for the video access
- vid_rvalid, out, 1, video read data valid (1 cycle)
- vid_rdata, out, DW, video read data
- mem_en, out, 1, memory port enable
- mem_we, out, 1, memory write enable
- mem_addr, out, AW, memory address
- mem_wdata, out, DW, memory write data
- mem_rdata, in, DW, memory read data, READ_LAT cycles after the enable edge

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - While reset is low: state ARB_IDLE, beat and wait counters 0, tag pipeline cleared.
  - While reset is low, all gnt/rvalid/mem_en/mem_we are 0; rdata/mem_addr/mem_wdata are 0.
  - Reset asserted mid-access drops in-flight reads; no rvalid is produced for them.
- Grant logic:
  - Grants are combinational from req and registered state. At most one gnt per cycle.
  - mem_en = cpu_gnt | vid_gnt.
  - mem_addr/mem_we/mem_wdata are muxed from the granted port in the same cycle.
  - mem_we is 1 only for a CPU store. Video never writes.
- Read return:
  - Issue cycle T of a read → owner's rvalid = 1 in cycle T+READ_LAT.
  - rdata = mem_rdata in that cycle, otherwise 0.
  - Stores produce no rvalid; the store completes at cpu_gnt.
  - Tag pipeline: a READ_LAT-deep shift register of {valid, owner}.
  - Back-to-back issue is allowed every cycle; returns stay in order.
- State machine:
  - ARB_IDLE:
    - vid_req and not CPU-forced → vid_gnt, beat=1, go to ARB_VID.
    - Else cpu_req → cpu_gnt.
  - ARB_VID:
    - vid_req, beat<BURST_LEN, and not CPU-forced → vid_gnt, beat+1.
    - Otherwise return to ARB_IDLE, granting the CPU that same cycle if cpu_req.
    - vid_req low ends the burst.
  - CPU-forced = cpu_req & wait==MAX_WAIT.
- Wait counter:
  - Increments on cpu_req & ~cpu_gnt, saturating at MAX_WAIT.
  - Clears on cpu_gnt, or when cpu_req is low.
- Boundary cases:
  - Simultaneous first requests in ARB_IDLE → video wins.
  - Burst limit reached with cpu_req → CPU granted next, then video may restart a burst.
  - Burst limit reached, no cpu_req → one ARB_IDLE cycle, then video may re-grant (1-cycle bubble).
- Throughput: no deadlock. The worst-case CPU wait is min(MAX_WAIT, BURST_LEN) cycles.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Burst mode and the wait counter are removed.
  - On conflict, grant alternates via a last-winner flop (reset = CPU last, so video wins the first conflict).
  - An uncontested requester is always granted.
- Undefined: burst-priority scheme as above.

Test Plan:
- Reset, then CPU-only loads to addr 0x0010, 0x0011 on consecutive cycles, READ_LAT=1 → cpu_gnt both cycles; cpu_rvalid in cycles T+1, T+2 with mem contents 0xBEEF, 0x1234; vid_rvalid stays 0.
- CPU store 0x00A0←0x5A5A → mem_en=mem_we=1, mem_addr=0x00A0, mem_wdata=0x5A5A in the grant cycle; no cpu_rvalid; a following load of 0x00A0 returns 0x5A5A.
- vid_req held continuously, cpu_req raised at burst beat 2, BURST_LEN=8, MAX_WAIT=6 → 6 wait cycles, then cpu_gnt; video resumes the next cycle; every vid_rvalid arrives exactly READ_LAT after its vid_gnt.
- Both requests held continuously with MAX_WAIT=15 → video gets 8 grants, then 1 CPU grant, repeating; never two gnt in one cycle.
- Reset pulsed low with 2 reads in flight (READ_LAT=2) → all outputs 0 immediately; no rvalid after release; state ARB_IDLE.
- With ARB_ROUND_ROBIN_EN, both requests held → grants alternate V,C,V,C… starting with V.
